if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
Instruction-fetch stage and IF/ID pipeline register. It feeds the decode stage.
- Holds the PC and issues word reads to instruction memory, with at most one request outstanding.
- Presents {instruction, PC, valid} to decode.
- Honours a stall from the hazard logic and a taken-branch/jump redirect from EX, dropping any stale fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on o_instr when o_valid=0 (addi x0,x0,0)

Ports:
i_clk  in  1  clock, rising-edge
i_rst  in  1  reset, synchronous, active-high
i_stall  in  1  hold the IF/ID outputs (hazard unit)
i_redirect  in  1  flush and redirect (EX, taken branch/JAL/JALR)
i_redirectPc  in  32  redirect target
o_imemReq  out  1  fetch request valid
o_imemAddr  out  32  fetch word address
i_imemReady  in  1  memory accepts request this cycle
i_imemRvalid  in  1  read data valid
i_imemRdata  in  32  read data
o_instr  out  32  instruction to decode
o_pc  out  32  PC of o_instr
o_valid  out  1  o_instr/o_pc hold a real instruction

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, skid empty.
  - o_valid=0, o_instr=NOP_INSTR, o_pc=0.
  - o_imemReq=0 during any cycle with i_rst=1.
- Reset mid-operation: the in-flight request is abandoned. The instruction memory shares i_rst.
- States: FETCH, WAIT, DRAIN.
- o_imemReq = (state==FETCH) && !skidValid && !i_redirect && !i_rst. o_imemAddr = pc.
  - addr is stable while a request is held with i_imemReady=0.
- Handshake (FETCH):
  - A request is accepted when o_imemReq && i_imemReady.
  - On acceptance: reqPc<=pc, pc<=pc+4 (mod 2^32, so 0xFFFF_FFFC wraps to 0), state->WAIT.
- WAIT on i_imemRvalid: state->FETCH.
  - If i_stall=1 && o_valid=1, {rdata, reqPc} goes into the 1-entry skid; no new request is issued while the skid is full.
  - Otherwise the IF/ID register loads o_instr=rdata, o_pc=reqPc, o_valid=1.
- i_imemRvalid in FETCH is ignored.
- IF/ID update when i_stall=0:
  - Load from the skid if it is full; the skid empties.
  - Else load from a same-cycle response.
  - Else o_valid<=0, o_instr<=NOP_INSTR (bubble).
- When i_stall=1: IF/ID holds all values.
- Redirect (highest priority; overrides i_stall):
  - pc<={i_redirectPc[31:2],2'b00}.
  - o_valid<=0, o_instr<=NOP_INSTR, skid cleared.
- Redirect state transitions:
  - In WAIT without rvalid: ->DRAIN.
  - In WAIT with same-cycle rvalid: the data is discarded; ->FETCH.
  - In FETCH: no request is accepted that cycle (req forced low); stays FETCH.
  - In DRAIN: stays DRAIN with the new pc.
- DRAIN: the next i_imemRvalid is discarded (no output change); ->FETCH.
- Latency and throughput:
  - Request accepted at cycle n with rvalid at n+1 gives o_valid=1 from cycle n+2.
  - Peak throughput is one instruction per 2 cycles.
  - The pc advances only on acceptance, never during stall-induced holds.

Test Plan:
- Fetch from reset:
  - Stimulus: release reset, i_imemReady=1, rvalid one cycle after each accept, rdata 0x00500093 then 0x00A00113.
  - Required: first req addr 0x0. o_valid=1, o_instr=0x00500093, o_pc=0x0 two cycles after accept. The next output has o_pc=0x4.
- Stall with response:
  - Stimulus: assert i_stall while o_valid=1 and a response for pc 0x4 arrives.
  - Required: outputs hold pc 0x0, o_imemReq=0 while the skid is full.
  - After i_stall falls: o_pc=0x4 the next cycle, then req addr 0x8.
- Redirect while outstanding:
  - Stimulus: in WAIT, pulse i_redirect with i_redirectPc=0x100.
  - Required: o_valid=0, o_instr=0x00000013. The later rvalid data is dropped. The next req addr is 0x100 and the next valid output has o_pc=0x100.
- Redirect vs. stall:
  - Stimulus: i_redirect=1 and i_stall=1 in the same cycle.
  - Required: flush wins, o_valid=0, the skid is emptied.
- Backpressure:
  - Stimulus: i_imemReady=0 for 3 cycles.
  - Required: o_imemReq=1 with o_imemAddr constant, the pc does not advance, and acceptance happens on cycle 4.
- Alignment and wrap:
  - Stimulus: redirect to 0x103.
  - Required: req addr 0x100.
  - Stimulus: redirect to 0xFFFF_FFFC, then complete one fetch.
  - Required: the following req addr is 0x0000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps at most one imem read outstanding; a 1-entry skid holds a response that lands during a stall.
module if_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirectPc,
  output logic        o_imemReq,
  output logic [31:0] o_imemAddr,
  input  logic        i_imemReady,
  input  logic        i_imemRvalid,
  input  logic [31:0] i_imemRdata,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] reqpc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        accept;
  logic        rsp;

  assign o_imemAddr = pc;

  always_comb begin
    o_imemReq = (state == S_FETCH) && !skid_valid && !i_redirect && !i_rst;
    accept    = o_imemReq && i_imemReady;
    rsp       = (state == S_WAIT) && i_imemRvalid && !i_redirect;
    state_nxt = state;
    case (state)
      S_FETCH: if (accept) state_nxt = S_WAIT;
      // a redirect with no response yet leaves one stale response to swallow
      S_WAIT: begin
        if (i_imemRvalid)    state_nxt = S_FETCH;
        else if (i_redirect) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (i_imemRvalid) state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc         <= RESET_PC;
      reqpc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      o_valid    <= 1'b0;
      o_instr    <= NOP_INSTR;
      o_pc       <= '0;
    end else if (i_redirect) begin
      pc         <= i_redirectPc & ~32'h3;
      skid_valid <= 1'b0;
      o_valid    <= 1'b0;
      o_instr    <= NOP_INSTR;
    end else begin
      if (accept) begin
        reqpc <= pc;
        pc    <= pc + 32'd4;
      end
      // skid fill and drain are mutually exclusive: a full skid blocks new requests
      if (rsp && i_stall && o_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= i_imemRdata;
        skid_pc    <= reqpc;
      end else if (!i_stall && skid_valid) begin
        skid_valid <= 1'b0;
        o_valid    <= 1'b1;
        o_instr    <= skid_instr;
        o_pc       <= skid_pc;
      end else if (rsp) begin
        o_valid <= 1'b1;
        o_instr <= i_imemRdata;
        o_pc    <= reqpc;
      end else if (!i_stall) begin
        o_valid <= 1'b0;
        o_instr <= NOP_INSTR;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic, all cycles checked
// against a transaction-level model (busy/drop flags plus a skid queue) driving a latency-randomised memory.
module tb_if_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rst, i_stall, i_redirect, i_imemReady, i_imemRvalid;
  logic [31:0] i_redirectPc, i_imemRdata;
  logic        o_imemReq, o_valid;
  logic [31:0] o_imemAddr, o_instr, o_pc;

  if_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_redirect(i_redirect),
    .i_redirectPc(i_redirectPc), .o_imemReq(o_imemReq), .o_imemAddr(o_imemAddr),
    .i_imemReady(i_imemReady), .i_imemRvalid(i_imemRvalid), .i_imemRdata(i_imemRdata),
    .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // stimulus knobs
  logic        rst_v, stall_v, redir_v, ready_v;
  logic [31:0] rpc_v;
  int unsigned lat_lo = 1, lat_hi = 1;
  bit          spur_en = 1'b0;

  // reference model
  typedef struct packed { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        skidq[$];
  logic [31:0] m_pc, m_reqpc, m_instr, m_opc;
  bit          m_busy, m_drop, m_valid;

  // memory model
  bit          mem_pend;
  logic [31:0] mem_addr;
  int unsigned mem_cnt;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_instr, obs_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0033;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_reqpc = 32'h0; m_instr = NOP; m_opc = 32'h0;
    m_busy = 1'b0; m_drop = 1'b0; m_valid = 1'b0;
    skidq.delete();
    mem_pend = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
  endtask

  task automatic step();
    bit          fire, spur, rv, m_req, acc, resp, got;
    logic [31:0] data, acc_addr;
    ent_t        e;
    fire = mem_pend && (mem_cnt == 0);
    spur = spur_en && !mem_pend && ($urandom_range(3) == 0);
    rv   = fire || spur;
    data = fire ? memf(mem_addr) : $urandom;
    i_rst = rst_v; i_stall = stall_v; i_redirect = redir_v; i_redirectPc = rpc_v;
    i_imemReady = ready_v; i_imemRvalid = rv; i_imemRdata = data;
    m_req    = !m_busy && (skidq.size() == 0) && !redir_v && !rst_v;
    acc      = m_req && ready_v;
    acc_addr = m_pc;

    @(negedge i_clk);
    obs_req = o_imemReq; obs_addr = o_imemAddr; obs_valid = o_valid;
    obs_instr = o_instr; obs_pc = o_pc;
    chk("req",   {31'b0, obs_req},   {31'b0, m_req});
    chk("addr",  obs_addr,           m_pc);
    chk("valid", {31'b0, obs_valid}, {31'b0, m_valid});
    chk("instr", obs_instr,          m_instr);
    chk("pc",    obs_pc,             m_opc);

    if (rst_v) begin
      model_reset();
    end else begin
      resp = m_busy && rv;
      got  = resp && !m_drop && !redir_v;
      if (redir_v) begin
        m_pc = rpc_v & ~32'h3;
        m_valid = 1'b0; m_instr = NOP;
        skidq.delete();
        if (resp) begin m_busy = 1'b0; m_drop = 1'b0; end
        else if (m_busy) m_drop = 1'b1;
      end else begin
        if (resp) begin m_busy = 1'b0; m_drop = 1'b0; end
        if (got && stall_v && m_valid) begin
          skidq.push_back('{instr: data, pc: m_reqpc});
        end else if (!stall_v && skidq.size() > 0) begin
          e = skidq.pop_front();
          m_valid = 1'b1; m_instr = e.instr; m_opc = e.pc;
        end else if (got) begin
          m_valid = 1'b1; m_instr = data; m_opc = m_reqpc;
        end else if (!stall_v) begin
          m_valid = 1'b0; m_instr = NOP;
        end
        if (acc) begin
          m_reqpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1; m_drop = 1'b0;
        end
      end
      if (fire) mem_pend = 1'b0;
      else if (mem_pend) mem_cnt--;
      if (acc) begin
        mem_pend = 1'b1; mem_addr = acc_addr;
        mem_cnt  = $urandom_range(lat_hi, lat_lo) - 1;
      end
    end
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    model_reset();
    rst_v = 1'b1; stall_v = 1'b0; redir_v = 1'b0; ready_v = 1'b0; rpc_v = 32'h0;
    i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirectPc = 32'h0;
    i_imemReady = 1'b0; i_imemRvalid = 1'b0; i_imemRdata = 32'h0;
    @(posedge i_clk);
    #1;

    // reset state
    step();
    chk("rst_valid", {31'b0, obs_valid}, 32'h0);
    chk("rst_instr", obs_instr, NOP);
    chk("rst_pc", obs_pc, 32'h0);
    chk("rst_req", {31'b0, obs_req}, 32'h0);

    // fetch from reset
    rst_v = 1'b0; ready_v = 1'b1;
    step();
    chk("first_req", {31'b0, obs_req}, 32'h1);
    chk("first_addr", obs_addr, 32'h0);
    step();
    stall_v = 1'b1;
    step();
    chk("first_valid", {31'b0, obs_valid}, 32'h1);
    chk("first_instr", obs_instr, 32'h0050_0093);
    chk("first_pc", obs_pc, 32'h0);

    // stall while the pc 0x4 response arrives
    step();
    step();
    chk("skid_noreq", {31'b0, obs_req}, 32'h0);
    chk("stall_hold_pc", obs_pc, 32'h0);
    stall_v = 1'b0;
    step();
    lat_lo = 2; lat_hi = 2;
    step();
    chk("skid_pc", obs_pc, 32'h4);
    chk("skid_instr", obs_instr, 32'h00A0_0113);
    chk("after_skid_addr", obs_addr, 32'h8);

    // redirect while outstanding
    redir_v = 1'b1; rpc_v = 32'h100;
    step();
    redir_v = 1'b0; lat_lo = 1; lat_hi = 1;
    step();
    chk("flush_valid", {31'b0, obs_valid}, 32'h0);
    chk("flush_instr", obs_instr, NOP);
    step();
    chk("redir_addr", obs_addr, 32'h100);
    step();
    stall_v = 1'b1;
    step();
    chk("redir_pc", obs_pc, 32'h100);

    // redirect and stall together with a full skid; also misaligned target
    step();
    redir_v = 1'b1; rpc_v = 32'h103;
    step();
    redir_v = 1'b0; ready_v = 1'b0;
    step();
    chk("flush_stall_valid", {31'b0, obs_valid}, 32'h0);
    chk("skid_emptied_req", {31'b0, obs_req}, 32'h1);
    chk("align_addr", obs_addr, 32'h100);

    // backpressure
    stall_v = 1'b0;
    step();
    chk("bp_addr1", obs_addr, 32'h100);
    step();
    chk("bp_addr2", obs_addr, 32'h100);
    ready_v = 1'b1;
    step();
    chk("bp_accept_req", {31'b0, obs_req}, 32'h1);
    step();
    chk("bp_pc_adv", obs_addr, 32'h104);

    // wrap at the top of the address space
    redir_v = 1'b1; rpc_v = 32'hFFFF_FFFC;
    step();
    chk("bp_out_pc", obs_pc, 32'h100);
    redir_v = 1'b0;
    step();
    chk("wrap_req_addr", obs_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_addr", obs_addr, 32'h0);
    step();
    chk("wrap_out_pc", obs_pc, 32'hFFFF_FFFC);
    chk("wrap_next_req", {31'b0, obs_req}, 32'h1);

    // reset mid-operation
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    step();
    chk("post_rst_addr", obs_addr, 32'h0);

    // random traffic
    lat_lo = 1; lat_hi = 3; spur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      rst_v   = ($urandom_range(199) == 0);
      stall_v = ($urandom_range(3) == 0);
      redir_v = ($urandom_range(9) == 0);
      rpc_v   = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      ready_v = ($urandom_range(2) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
